// File: rtl/req_gnt_mon_pkg.sv
// Shared definitions for the request/grant latency monitor.
// Holds the per-channel FSM state enum, the failure-cause encoding and
// small helpers used by the top-level totals counters.
package req_gnt_mon_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ch_state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_EOT     = 2'b10;

    typedef enum logic [1:0] {
        C_NONE    = CAUSE_NONE,
        C_TIMEOUT = CAUSE_TIMEOUT,
        C_EOT     = CAUSE_EOT
    } cause_e;

    localparam int unsigned TOT_W = 16;

    // Number of set bits in a (zero-extended) channel pulse vector.
    function automatic logic [5:0] popcnt32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

    // Totals add with saturation at all-ones.
    function automatic logic [TOT_W-1:0] sat_add16(input logic [TOT_W-1:0] a,
                                                   input logic [5:0]       b);
        logic [TOT_W:0] s;
        s = {1'b0, a} + {11'b0, b};
        return s[TOT_W] ? 16'hFFFF : s[TOT_W-1:0];
    endfunction

endpackage

// File: rtl/req_gnt_monitor_if.sv
// Request/grant bus observed by the monitor.
//   req[NUM_CH] : per-channel request levels
//   gnt[NUM_CH] : per-channel grant levels
//   eot         : one-cycle end-of-test strobe
// master drives the bus, slave (the monitor) only observes it.
interface req_gnt_monitor_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic              eot;

    modport master (output req, output gnt, output eot);
    modport slave  (input  req, input  gnt, input  eot);
endinterface

// File: rtl/req_gnt_mon_ch.sv
// One monitored req/gnt channel.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   i_req, i_gnt, i_eot     : channel request, grant, end-of-test
//   o_pass, o_fail          : registered one-cycle result pulses
//   o_pass_set, o_fail_set  : the same pulses one cycle early (feed totals)
//   o_cause                 : cause of the last fail (00/01/10)
//   o_pending               : high while waiting for a grant
//   o_lat                   : latency k of the last pass or fail
module req_gnt_mon_ch
    import req_gnt_mon_pkg::*;
#(
    parameter int MIN_DLY = 3,
    parameter int MAX_DLY = 0,
    parameter int STRONG  = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic             i_gnt,
    input  logic             i_eot,
    output logic             o_pass,
    output logic             o_fail,
    output logic             o_pass_set,
    output logic             o_fail_set,
    output logic [1:0]       o_cause,
    output logic             o_pending,
    output logic [CNT_W-1:0] o_lat
);

    localparam logic [CNT_W-1:0] K_SAT = '1;
    localparam logic [31:0]      MIN_U = 32'(MIN_DLY);
    localparam logic [31:0]      MAX_U = 32'(MAX_DLY);

    ch_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_k, w_k_nxt, w_k_inc;
    logic             r_req_d, r_gnt_d;
    logic             r_pass, r_fail, w_pass_nxt, w_fail_nxt;
    cause_e           r_cause, w_cause_nxt;
    logic [CNT_W-1:0] r_lat, w_lat_nxt;
    logic             w_req_rise, w_gnt_rise, w_match, w_timeout;

    assign w_req_rise = i_req & ~r_req_d;
    assign w_gnt_rise = i_gnt & ~r_gnt_d;

    // k as seen on the current edge: one more than the stored count.
    assign w_k_inc   = (r_k == K_SAT) ? K_SAT : r_k + 1'b1;
    assign w_match   = w_gnt_rise && (32'(w_k_inc) >= MIN_U) &&
                       ((MAX_DLY == 0) || (32'(w_k_inc) <= MAX_U));
    assign w_timeout = (MAX_DLY != 0) && (32'(w_k_inc) == MAX_U);

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_pass_nxt  = 1'b0;
        w_fail_nxt  = 1'b0;
        w_cause_nxt = r_cause;
        w_lat_nxt   = r_lat;
        case (r_state)
            ST_IDLE: begin
                if (w_req_rise) begin
                    w_state_nxt = ST_WAIT;
                    w_k_nxt     = '0;
                end
            end
            ST_WAIT: begin
                w_k_nxt = w_k_inc;
                // Priority: match, then timeout, then end-of-test.
                if (w_match) begin
                    w_state_nxt = ST_IDLE;
                    w_pass_nxt  = 1'b1;
                    w_lat_nxt   = w_k_inc;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_fail_nxt  = 1'b1;
                    w_cause_nxt = C_TIMEOUT;
                    w_lat_nxt   = w_k_inc;
                end else if (i_eot) begin
                    w_state_nxt = ST_IDLE;
                    if (STRONG != 0) begin
                        w_fail_nxt  = 1'b1;
                        w_cause_nxt = C_EOT;
                        w_lat_nxt   = w_k_inc;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_req_d <= 1'b0;
            r_gnt_d <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_cause <= C_NONE;
            r_lat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_req_d <= i_req;
            r_gnt_d <= i_gnt;
            r_pass  <= w_pass_nxt;
            r_fail  <= w_fail_nxt;
            r_cause <= w_cause_nxt;
            r_lat   <= w_lat_nxt;
        end
    end

    assign o_pass     = r_pass;
    assign o_fail     = r_fail;
    assign o_pass_set = w_pass_nxt;
    assign o_fail_set = w_fail_nxt;
    assign o_cause    = r_cause;
    assign o_pending  = (r_state == ST_WAIT);
    assign o_lat      = r_lat;

endmodule

// File: rtl/req_gnt_monitor.sv
// Multi-channel request/grant latency monitor.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   bus         : req/gnt/eot observed through req_gnt_monitor_if.slave
//   pass_o      : per-channel one-cycle pass pulse
//   fail_o      : per-channel one-cycle fail pulse
//   cause_o     : 2 bits per channel, cause of the last fail
//   pending_o   : per-channel waiting-for-grant flag
//   lat_o       : CNT_W bits per channel, latency of the last pass/fail
//   pass_cnt_o, fail_cnt_o : saturating totals over all channels
module req_gnt_monitor
    import req_gnt_mon_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIN_DLY = 3,
    parameter int MAX_DLY = 0,
    parameter int STRONG  = 0,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    req_gnt_monitor_if.slave          bus,
    output logic [NUM_CH-1:0]         pass_o,
    output logic [NUM_CH-1:0]         fail_o,
    output logic [2*NUM_CH-1:0]       cause_o,
    output logic [NUM_CH-1:0]         pending_o,
    output logic [CNT_W*NUM_CH-1:0]   lat_o,
    output logic [TOT_W-1:0]          pass_cnt_o,
    output logic [TOT_W-1:0]          fail_cnt_o
);

    logic [NUM_CH-1:0] w_pass_set, w_fail_set;
    logic [TOT_W-1:0]  r_pass_cnt, r_fail_cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        req_gnt_mon_ch #(
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY),
            .STRONG  (STRONG),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_req      (bus.req[g]),
            .i_gnt      (bus.gnt[g]),
            .i_eot      (bus.eot),
            .o_pass     (pass_o[g]),
            .o_fail     (fail_o[g]),
            .o_pass_set (w_pass_set[g]),
            .o_fail_set (w_fail_set[g]),
            .o_cause    (cause_o[2*g +: 2]),
            .o_pending  (pending_o[g]),
            .o_lat      (lat_o[g*CNT_W +: CNT_W])
        );
    end

    // Totals are fed from the pre-register pulses so they update on the
    // same edge the registered pulses appear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_pass_cnt <= sat_add16(r_pass_cnt, popcnt32(32'(w_pass_set)));
            r_fail_cnt <= sat_add16(r_fail_cnt, popcnt32(32'(w_fail_set)));
        end
    end

    assign pass_cnt_o = r_pass_cnt;
    assign fail_cnt_o = r_fail_cnt;

endmodule

// File: tb/tb_req_gnt_monitor.sv
module tb_req_gnt_monitor;

    localparam int NI   = 4;
    localparam int KSAT = 255;
    // Instance parameter sets (must match the instantiations below).
    localparam int P_NCH [NI] = '{4, 4, 4, 32};
    localparam int P_MIN [NI] = '{3, 3, 3, 1};
    localparam int P_MAX [NI] = '{0, 0, 10, 1};
    localparam int P_STR [NI] = '{0, 1, 1, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    req_gnt_monitor_if #(.NUM_CH(4))  bus4 ();
    req_gnt_monitor_if #(.NUM_CH(32)) bus32 ();

    logic [3:0]   pass_0, fail_0, pend_0, pass_1, fail_1, pend_1, pass_2, fail_2, pend_2;
    logic [7:0]   cause_0, cause_1, cause_2;
    logic [31:0]  lat_0, lat_1, lat_2;
    logic [31:0]  pass_3, fail_3, pend_3;
    logic [63:0]  cause_3;
    logic [255:0] lat_3;
    logic [15:0]  pc_0, fc_0, pc_1, fc_1, pc_2, fc_2, pc_3, fc_3;

    req_gnt_monitor #(.NUM_CH(4), .MIN_DLY(3), .MAX_DLY(0), .STRONG(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .pass_o(pass_0), .fail_o(fail_0),
        .cause_o(cause_0), .pending_o(pend_0), .lat_o(lat_0), .pass_cnt_o(pc_0), .fail_cnt_o(fc_0));
    req_gnt_monitor #(.NUM_CH(4), .MIN_DLY(3), .MAX_DLY(0), .STRONG(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .pass_o(pass_1), .fail_o(fail_1),
        .cause_o(cause_1), .pending_o(pend_1), .lat_o(lat_1), .pass_cnt_o(pc_1), .fail_cnt_o(fc_1));
    req_gnt_monitor #(.NUM_CH(4), .MIN_DLY(3), .MAX_DLY(10), .STRONG(1), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .pass_o(pass_2), .fail_o(fail_2),
        .cause_o(cause_2), .pending_o(pend_2), .lat_o(lat_2), .pass_cnt_o(pc_2), .fail_cnt_o(fc_2));
    req_gnt_monitor #(.NUM_CH(32), .MIN_DLY(1), .MAX_DLY(1), .STRONG(1), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus32.slave), .pass_o(pass_3), .fail_o(fail_3),
        .cause_o(cause_3), .pending_o(pend_3), .lat_o(lat_3), .pass_cnt_o(pc_3), .fail_cnt_o(fc_3));

    logic [31:0]  a_pass [NI], a_fail [NI], a_pend [NI];
    logic [63:0]  a_cause [NI];
    logic [255:0] a_lat [NI];
    logic [15:0]  a_pc [NI], a_fc [NI];

    assign a_pass[0] = 32'(pass_0);  assign a_fail[0] = 32'(fail_0);  assign a_pend[0] = 32'(pend_0);
    assign a_pass[1] = 32'(pass_1);  assign a_fail[1] = 32'(fail_1);  assign a_pend[1] = 32'(pend_1);
    assign a_pass[2] = 32'(pass_2);  assign a_fail[2] = 32'(fail_2);  assign a_pend[2] = 32'(pend_2);
    assign a_pass[3] = pass_3;       assign a_fail[3] = fail_3;       assign a_pend[3] = pend_3;
    assign a_cause[0] = 64'(cause_0); assign a_cause[1] = 64'(cause_1);
    assign a_cause[2] = 64'(cause_2); assign a_cause[3] = cause_3;
    assign a_lat[0] = 256'(lat_0);   assign a_lat[1] = 256'(lat_1);
    assign a_lat[2] = 256'(lat_2);   assign a_lat[3] = lat_3;
    assign a_pc[0] = pc_0; assign a_pc[1] = pc_1; assign a_pc[2] = pc_2; assign a_pc[3] = pc_3;
    assign a_fc[0] = fc_0; assign a_fc[1] = fc_1; assign a_fc[2] = fc_2; assign a_fc[3] = fc_3;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (time-stamp based) ----------------
    typedef struct {
        int lat;
        int cause;
    } ev_t;

    typedef struct {
        logic [31:0] pm;
        logic [31:0] fm;
        logic [31:0] pend;
        int          pc;
        int          fc;
    } st_t;

    bit   m_pend  [NI][32];
    int   m_start [NI][32];
    bit   m_pr    [NI][32];
    bit   m_pg    [NI][32];
    int   m_cause [NI][32];
    int   m_pc [NI];
    int   m_fc [NI];
    int   m_cyc;
    ev_t  evq [NI][32][$];
    st_t  stq [NI][$];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < 32; c++) begin
                m_pend[i][c] = 0; m_start[i][c] = 0; m_pr[i][c] = 0;
                m_pg[i][c] = 0;   m_cause[i][c] = 0;
                evq[i][c].delete();
            end
            m_pc[i] = 0; m_fc[i] = 0;
            stq[i].delete();
        end
        m_cyc = 0;
    endtask

    // Evaluate what instance i decides on the coming edge for inputs r/g/e.
    task automatic model_step(input int i, input logic [31:0] r, input logic [31:0] g, input logic e);
        st_t s;
        int np, nf, k;
        s.pm = '0; s.fm = '0; s.pend = '0;
        np = 0; nf = 0;
        for (int c = 0; c < P_NCH[i]; c++) begin
            bit rr, gr, fire;
            ev_t ev;
            rr = r[c] && !m_pr[i][c];
            gr = g[c] && !m_pg[i][c];
            fire = 0;
            if (!m_pend[i][c]) begin
                if (rr) begin
                    m_pend[i][c]  = 1;
                    m_start[i][c] = m_cyc;
                end
            end else begin
                k = m_cyc - m_start[i][c];
                if (k > KSAT) k = KSAT;
                ev.lat = k;
                if (gr && k >= P_MIN[i] && (P_MAX[i] == 0 || k <= P_MAX[i])) begin
                    m_pend[i][c] = 0; s.pm[c] = 1; np++; fire = 1;
                end else if (P_MAX[i] != 0 && k == P_MAX[i]) begin
                    m_pend[i][c] = 0; s.fm[c] = 1; nf++; fire = 1;
                    m_cause[i][c] = 1;
                end else if (e) begin
                    m_pend[i][c] = 0;
                    if (P_STR[i] != 0) begin
                        s.fm[c] = 1; nf++; fire = 1;
                        m_cause[i][c] = 2;
                    end
                end
                ev.cause = m_cause[i][c];
                if (fire) evq[i][c].push_back(ev);
            end
            m_pr[i][c] = r[c];
            m_pg[i][c] = g[c];
            s.pend[c] = m_pend[i][c];
        end
        m_pc[i] = (m_pc[i] + np > 65535) ? 65535 : m_pc[i] + np;
        m_fc[i] = (m_fc[i] + nf > 65535) ? 65535 : m_fc[i] + nf;
        s.pc = m_pc[i];
        s.fc = m_fc[i];
        stq[i].push_back(s);
    endtask

    task automatic drive(input logic [3:0] r4, input logic [3:0] g4, input logic e4,
                         input logic [31:0] r32, input logic [31:0] g32);
        @(negedge clk);
        bus4.req = r4;   bus4.gnt = g4;   bus4.eot = e4;
        bus32.req = r32; bus32.gnt = g32; bus32.eot = 1'b0;
        for (int i = 0; i < NI; i++) begin
            if (i < 3) model_step(i, {28'b0, r4}, {28'b0, g4}, e4);
            else       model_step(i, r32, g32, 1'b0);
        end
        m_cyc++;
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int t = 0; t < n; t++) drive(4'h0, 4'h0, 1'b0, '0, '0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                for (int i = 0; i < NI; i++) begin
                    st_t s;
                    if (stq[i].size() == 0) begin
                        chk($sformatf("i%0d_sb_empty", i), 64'(1), 64'(0));
                    end else begin
                        s = stq[i].pop_front();
                        chk($sformatf("i%0d_pass_mask", i), 64'(a_pass[i]), 64'(s.pm));
                        chk($sformatf("i%0d_fail_mask", i), 64'(a_fail[i]), 64'(s.fm));
                        chk($sformatf("i%0d_pending", i), 64'(a_pend[i]), 64'(s.pend));
                        chk($sformatf("i%0d_pass_cnt", i), 64'(a_pc[i]), 64'(s.pc));
                        chk($sformatf("i%0d_fail_cnt", i), 64'(a_fc[i]), 64'(s.fc));
                        for (int c = 0; c < P_NCH[i]; c++) begin
                            if ((s.pm[c] || s.fm[c]) && evq[i][c].size() > 0) begin
                                ev_t ev;
                                ev = evq[i][c].pop_front();
                                chk($sformatf("i%0d_c%0d_lat", i, c), 64'(a_lat[i][c*8 +: 8]), 64'(ev.lat));
                                chk($sformatf("i%0d_c%0d_cause", i, c), 64'(a_cause[i][c*2 +: 2]), 64'(ev.cause));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic async_reset_check();
        @(negedge clk);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_i%0d_pass", i), 64'(a_pass[i]), 64'(0));
            chk($sformatf("rst_i%0d_fail", i), 64'(a_fail[i]), 64'(0));
            chk($sformatf("rst_i%0d_pend", i), 64'(a_pend[i]), 64'(0));
            chk($sformatf("rst_i%0d_cause", i), 64'(a_cause[i]), 64'(0));
            chk($sformatf("rst_i%0d_lat", i), 64'(|a_lat[i]), 64'(0));
            chk($sformatf("rst_i%0d_cnt", i), 64'({a_pc[i], a_fc[i]}), 64'(0));
        end
        bus4.req = '0; bus4.gnt = '0; bus4.eot = 1'b0;
        bus32.req = '0; bus32.gnt = '0; bus32.eot = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  r4, g4;
        logic        e4;
        logic [31:0] r32, g32;

        bus4.req = '0; bus4.gnt = '0; bus4.eot = 1'b0;
        bus32.req = '0; bus32.gnt = '0; bus32.eot = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("init_i%0d_pend", i), 64'(a_pend[i]), 64'(0));
            chk($sformatf("init_i%0d_cnt", i), 64'({a_pc[i], a_fc[i]}), 64'(0));
        end
        rst_n = 1'b1;

        // req rise at cycle 0, gnt rise at cycle 7
        for (int t = 0; t <= 7; t++) drive(4'b0001, (t == 7) ? 4'b0001 : 4'b0000, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk("basic_pass", 64'(pass_0[0]), 64'(1));
        chk("basic_lat", 64'(lat_0[7:0]), 64'(7));
        chk("basic_cnt", 64'(pc_0), 64'(1));
        idle(2);

        // early gnt at k=1 ignored, pass at k=4
        for (int t = 0; t <= 4; t++) drive(4'b0010, (t == 1 || t == 4) ? 4'b0010 : 4'b0000, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk("early_gnt_pass", 64'(pass_0[1]), 64'(1));
        chk("early_gnt_nofail", 64'(fail_0), 64'(0));
        chk("early_gnt_lat", 64'(lat_0[15:8]), 64'(4));
        idle(2);

        // timeout at k=10 on the MAX_DLY=10 instance
        for (int t = 0; t <= 10; t++) drive(4'b0010, 4'b0000, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk("timeout_fail", 64'(fail_2[1]), 64'(1));
        chk("timeout_cause", 64'(cause_2[3:2]), 64'(1));
        chk("timeout_pend", 64'(pend_2[1]), 64'(0));
        idle(2);

        // eot at cycle 20: STRONG=1 fails, STRONG=0 silently drops
        for (int t = 0; t <= 20; t++) drive(4'b0100, 4'b0000, (t == 20), '0, '0);
        @(posedge clk); #1;
        chk("eot_strong_fail", 64'(fail_1[2]), 64'(1));
        chk("eot_strong_cause", 64'(cause_1[5:4]), 64'(2));
        chk("eot_weak_nofail", 64'(fail_0), 64'(0));
        chk("eot_weak_pend", 64'(pend_0[2]), 64'(0));
        idle(2);

        // latency counter saturation with unbounded MAX_DLY
        for (int t = 0; t <= 300; t++) drive(4'b1000, (t == 300) ? 4'b1000 : 4'b0000, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk("sat_pass", 64'(pass_0[3]), 64'(1));
        chk("sat_lat", 64'(lat_0[31:24]), 64'(KSAT));
        idle(2);

        // all channels pass on one edge
        for (int t = 0; t <= 5; t++) drive(4'b1111, (t == 5) ? 4'b1111 : 4'b0000, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk("all_pass", 64'(pass_0), 64'(4'hF));
        idle(2);

        // async reset mid-request at k=5, then a fresh request
        for (int t = 0; t <= 5; t++) drive(4'b0001, 4'b0000, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk("pre_rst_pend", 64'(pend_0[0]), 64'(1));
        async_reset_check();
        for (int t = 0; t <= 4; t++) drive(4'b0001, (t == 4) ? 4'b0001 : 4'b0000, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk("post_rst_pass", 64'(pass_0[0]), 64'(1));
        chk("post_rst_lat", 64'(lat_0[7:0]), 64'(4));
        chk("post_rst_cnt", 64'(pc_0), 64'(1));
        idle(2);

        // random traffic; the 32-channel instance runs a req/gnt pattern
        // that drives both totals into saturation
        r4 = '0;
        for (int t = 0; t < 12000; t++) begin
            r4  = r4 ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            g4  = 4'($urandom) & 4'($urandom);
            e4  = ($urandom_range(0, 63) == 0);
            r32 = (t % 2 == 0) ? '1 : '0;
            g32 = (t % 2 == 0) ? '0 : $urandom;
            drive(r4, g4, e4, r32, g32);
        end
        idle(4);
        @(posedge clk); #2;
        chk("sat_pass_cnt", 64'(pc_3), 64'(16'hFFFF));
        chk("sat_fail_cnt", 64'(fc_3), 64'(16'hFFFF));
        for (int i = 0; i < NI; i++) begin
            int left;
            left = 0;
            for (int c = 0; c < 32; c++) left += evq[i][c].size();
            chk($sformatf("i%0d_events_left", i), 64'(left), 64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_gnt_monitor.md
REQ_GNT_MONITOR -- requirements
Module: req_gnt_monitor

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent req/gnt channels, range 1..32.
REQ-002 Parameter MIN_DLY, default 3: minimum cycles from req rise to gnt rise, range 1..MAX_DLY (or any value >=1 when MAX_DLY=0).
REQ-003 Parameter MAX_DLY, default 0: maximum cycles from req rise to gnt rise; 0 means unbounded.
REQ-004 Parameter STRONG, default 0: 1 means a pending request at end of test is a failure; 0 means it is silently dropped.
REQ-005 Parameter CNT_W, default 8: latency counter width in bits.
REQ-006 clk  input  1  single clock; all logic samples on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 req  input  NUM_CH  per-channel request.
REQ-009 gnt  input  NUM_CH  per-channel grant.
REQ-010 eot  input  1  end-of-test strobe, one cycle wide.
REQ-011 pass_o  output  NUM_CH  one-cycle pulse per channel on a successful match.
REQ-012 fail_o  output  NUM_CH  one-cycle pulse per channel on a failure.
REQ-013 cause_o  output  2*NUM_CH  per-channel failure cause of the last fail: 00 none, 01 timeout, 10 unmatched at eot.
REQ-014 pending_o  output  NUM_CH  per-channel flag, high while the channel awaits a grant.
REQ-015 lat_o  output  CNT_W*NUM_CH  per-channel latency (k) of the last pass or fail.
REQ-016 pass_cnt_o, fail_cnt_o  output  16 each  totals across all channels, saturating at 0xFFFF.

Function
REQ-017 Rise detection SHALL use a registered previous sample: rise = current 1 and previous 0; previous samples reset to 0, so req high at the first sampled edge after reset counts as a rise.
REQ-018 Each channel SHALL use an FSM with states IDLE and WAIT; from IDLE, a req rise enters WAIT with k=0 on that edge.
REQ-019 In WAIT, k SHALL increment by 1 per edge and saturate at 2^CNT_W-1.
REQ-020 In WAIT, a gnt rise at k>=MIN_DLY and (MAX_DLY=0 or k<=MAX_DLY) SHALL go to IDLE and pulse pass_o.
REQ-021 A gnt rise at k<MIN_DLY SHALL be ignored; the channel keeps waiting.
REQ-022 With MAX_DLY>0, reaching k=MAX_DLY without a qualifying gnt rise SHALL go to IDLE, pulse fail_o and set cause 01.
REQ-023 With MAX_DLY=0, a saturated counter SHALL keep the channel in WAIT; lat_o then reports the saturated value.
REQ-024 A req rise while in WAIT SHALL be ignored; only one request is outstanding per channel.
REQ-025 A gnt rise and a req rise on the same edge in IDLE SHALL start a new request; that gnt does not match it.
REQ-026 eot while in WAIT SHALL go to IDLE; with STRONG=1 it pulses fail_o and sets cause 10, with STRONG=0 it produces no pulse.
REQ-027 eot on the same edge as a qualifying gnt rise SHALL produce a pass; match takes priority over eot and timeout.
REQ-028 pass_o, fail_o, cause_o and lat_o SHALL be registered and become valid one clock after the deciding edge.
REQ-029 pending_o SHALL be high exactly while the channel is in WAIT.
REQ-030 Each counter SHALL add, per cycle, the popcount of its pulses across all channels, saturating at 0xFFFF.

Reset
REQ-031 rst_n low SHALL immediately force all channels to IDLE and clear every output, counter, k and previous-sample register to 0, including mid-request.

Structure
REQ-032 A shared package req_gnt_mon_pkg SHALL hold the FSM state enum, the cause enum and the cause encoding constants.
REQ-033 The sub-module req_gnt_mon_ch SHALL implement one channel and be instantiated NUM_CH times by a generate loop; the top level holds the counters.

Verification
REQ-034 Default parameters, ch0 req rise at cycle 0, gnt rise at cycle 7 -> pass_o[0] pulses at cycle 8, lat=7, pass_cnt=1.
REQ-035 MAX_DLY=10, req rise, no gnt -> fail_o pulses at k=10+1 cycle, cause=01, pending drops.
REQ-036 Default parameters, gnt rise at k=1 then again at k=4 -> no fail, pass with lat=4.
REQ-037 STRONG=1, req rise, no gnt, eot at cycle 20 -> fail, cause=10; the same stimulus with STRONG=0 -> no pulse and pending cleared.
REQ-038 NUM_CH=4, all channels pass on the same edge -> pass_cnt increments by 4 in one cycle; a counter at 0xFFFF stays at 0xFFFF.
REQ-039 rst_n asserted at k=5 -> all outputs 0 asynchronously; a later req rise restarts with k=0.
